vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of every sprite controller and ROM fetch block: generates the raster coordinate counters `pixel`/`line` that those blocks decode, plus the VGA sync/blanking strobes.
- Sync and data-enable outputs are re-timed through a programmable delay line. They then line up with pixel colour that emerges from the sprite ROM read latency.
- Counting advances only on a pixel-clock enable, so the block runs from the 50 MHz system clock with a 25 MHz pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- SYNC_DLY, 2, pixel-enable ticks of delay applied to hsync/vsync/de (0..7)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, reset; asynchronous assert, active-low
- pix_en, input, 1, pixel-clock enable; one tick = one pixel
- pixel, output, `CORDW, horizontal position; 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
- line, output, `CORDW, vertical position; 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525
- hsync, output, 1, delayed horizontal sync
- vsync, output, 1, delayed vertical sync
- de, output, 1, delayed data enable (active video)
- line_start, output, 1, one-clk pulse on the tick where pixel becomes 0
- frame_start, output, 1, one-clk pulse on the tick where pixel and line both become 0
- frame_cnt, output, 16, frame counter; wraps 0xFFFF -> 0

Behaviour:
- Reset (rst_n low, async):
  - pixel = 0, line = 0, frame_cnt = 0
  - line_start = 0, frame_start = 0
  - de = 0; hsync = vsync = inactive level (!H_POL / !V_POL)
  - delay-line stages cleared to the inactive value
- Release: first pix_en tick moves pixel 0 -> 1. Coordinate (0,0) is valid for the first cycle after release.
- Counter advance, on each clk with pix_en = 1:
  - pixel < H_TOTAL-1: pixel + 1
  - otherwise pixel = 0, and line = (line == V_TOTAL-1) ? 0 : line + 1
- pix_en = 0: all counters, delay-line stages and outputs hold; pulses are forced to 0.
- Active region: pixel < H_ACTIVE and line < V_ACTIVE. Origin (0,0) is the first visible pixel; blanking follows active.
- Raw hsync is active for H_ACTIVE+H_FP <= pixel < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- Raw vsync is active for V_ACTIVE+V_FP <= line < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. Vsync changes level on the same tick as line.
- Raw de = active region.
- Raw signals are decoded combinationally from the current counters, then passed through a SYNC_DLY-stage shift register clocked by pix_en.
  - SYNC_DLY = 0: outputs are registered copies of raw with zero extra pix_en ticks, i.e. they update on the same edge as the counters.
  - pixel/line are never delayed; downstream sprite blocks depend on undelayed coordinates for prefetch.
- line_start and frame_start are registered. They are high for exactly one clk on the cycle after the edge where the counter wrapped to 0.
- frame_cnt increments on the same edge as the line wrap V_TOTAL-1 -> 0.
- Simultaneous pixel and line wrap: both line_start and frame_start pulse on the same cycle.
- Reset mid-frame: counters jump to 0 immediately. No pulse is produced for the forced zero; the next line_start occurs after a full H_TOTAL ticks.
- Counter widths: pixel/line compare against constants sized `CORDW. Elaboration fails (generate error) if H_TOTAL-1 or V_TOTAL-1 exceeds 2^`CORDW - 1.

Test Plan:
- Free run, pix_en every 2nd clk -> frame_start period = 800*525*2 = 840000 clk; line_start period = 1600 clk; frame_cnt increments by 1 each frame.
- Horizontal decode -> hsync low exactly 96 pix ticks; raw falling edge at pixel 656, observed at hsync after SYNC_DLY=2 ticks (pixel 658); de low for pixel 640..799 (delayed by 2).
- Vertical decode -> vsync low during lines 490..491 only; de never high on lines 480..524.
- pix_en held 0 for 50 clk at pixel 300, line 100 -> all outputs frozen, no pulses; resumes at pixel 301.
- rst_n asserted at pixel 400, line 200 -> same-cycle pixel = line = 0, hsync/vsync high, de low; after release, first line_start occurs 800 ticks later.
- SYNC_DLY=0 build with H_POL=V_POL=1 -> hsync high exactly at pixel 656..751, aligned with the counter edge; frame_cnt wraps 0xFFFF -> 0 (preload via forced frame count in the bench).

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-enable input plus coordinates, sync strobes and frame pulses.
`ifndef CORDW
`define CORDW 10
`endif

interface vga_timing_gen_if;
    logic              pix_en;
    logic [`CORDW-1:0] pixel;
    logic [`CORDW-1:0] line;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              line_start;
    logic              frame_start;
    logic [15:0]       frame_cnt;

    modport master (
        input  pix_en,
        output pixel, line, hsync, vsync, de, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  pixel, line, hsync, vsync, de, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster counters with sync/de re-timed through a pix_en-clocked delay line so they
// line up with pixel colour arriving after the sprite ROM latency.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned H_POL    = 0,
    parameter int unsigned V_POL    = 0,
    parameter int unsigned SYNC_DLY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned CORDW   = `CORDW;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL - 1 > (2 ** CORDW) - 1) begin : g_h_too_wide
        $error("H_TOTAL-1 does not fit in CORDW bits");
    end
    if (V_TOTAL - 1 > (2 ** CORDW) - 1) begin : g_v_too_wide
        $error("V_TOTAL-1 does not fit in CORDW bits");
    end
    if (SYNC_DLY > 7) begin : g_dly_range
        $error("SYNC_DLY must be 0..7");
    end

    localparam logic [CORDW-1:0] H_LAST    = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST    = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT_END = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT_END = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] H_SYNC_ST = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] H_SYNC_EN = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] V_SYNC_ST = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] V_SYNC_EN = CORDW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             H_LVL     = 1'(H_POL);
    localparam logic             V_LVL     = 1'(V_POL);
    // Delay-line word is {hsync, vsync, de}
    localparam logic [2:0]       IDLE      = {~H_LVL, ~V_LVL, 1'b0};

    logic [CORDW-1:0] pixel_q, pixel_d;
    logic [CORDW-1:0] line_q, line_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             hs_raw, vs_raw, de_raw;
    logic [2:0]       raw_d;
    logic [2:0]       dly_q [SYNC_DLY+1];

    always_comb begin
        pixel_d       = pixel_q;
        line_d        = line_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vga.pix_en) begin
            if (pixel_q == H_LAST) begin
                pixel_d      = '0;
                line_start_d = 1'b1;
                if (line_q == V_LAST) begin
                    line_d        = '0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end else begin
                    line_d = line_q + CORDW'(1);
                end
            end else begin
                pixel_d = pixel_q + CORDW'(1);
            end
        end
    end

    // Decode from next-state counters so stage 0 lands on the same edge as the counters.
    always_comb begin
        hs_raw = (pixel_d >= H_SYNC_ST) && (pixel_d < H_SYNC_EN);
        vs_raw = (line_d >= V_SYNC_ST) && (line_d < V_SYNC_EN);
        de_raw = (pixel_d < H_ACT_END) && (line_d < V_ACT_END);
        raw_d  = {hs_raw ? H_LVL : ~H_LVL, vs_raw ? V_LVL : ~V_LVL, de_raw};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q       <= '0;
            line_q        <= '0;
            frame_cnt_q   <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_q       <= pixel_d;
            line_q        <= line_d;
            frame_cnt_q   <= frame_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= SYNC_DLY; i++) begin
                dly_q[i] <= IDLE;
            end
        end else if (vga.pix_en) begin
            dly_q[0] <= raw_d;
            for (int unsigned i = 1; i <= SYNC_DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign vga.pixel       = pixel_q;
    assign vga.line        = line_q;
    assign vga.frame_cnt   = frame_cnt_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = dly_q[SYNC_DLY][2];
    assign vga.vsync       = dly_q[SYNC_DLY][1];
    assign vga.de          = dly_q[SYNC_DLY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size default instance and a tiny-raster instance (SYNC_DLY=0,
// active-high syncs) checked every clock against an arithmetic tick-count model.
`ifndef CORDW
`define CORDW 10
`endif

module tb_vga_timing_gen;

    localparam int B_HA = 6, B_HFP = 2, B_HS = 3, B_HBP = 2;
    localparam int B_VA = 4, B_VFP = 2, B_VS = 2, B_VBP = 1;

    typedef struct packed {
        logic [`CORDW-1:0] pixel;
        logic [`CORDW-1:0] line;
        logic              hsync;
        logic              vsync;
        logic              de;
        logic              ls;
        logic              fs;
        logic [15:0]       fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .vga   (if_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
        .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
        .H_POL    (1),    .V_POL (1),    .SYNC_DLY (0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .vga   (if_b)
    );

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          n[2];
    logic [15:0] fc_base[2];
    int          vectors = 0;
    int          misc    = 0;

    function automatic int htot(int id);
        return id != 0 ? B_HA + B_HFP + B_HS + B_HBP : 800;
    endfunction

    function automatic int vtot(int id);
        return id != 0 ? B_VA + B_VFP + B_VS + B_VBP : 525;
    endfunction

    function automatic logic [2:0] idle(int id);
        return id != 0 ? 3'b000 : 3'b110;
    endfunction

    // Sync/de the spec's rules give for the raster position reached after m ticks.
    function automatic logic [2:0] raw(int id, int m);
        int ha  = id != 0 ? B_HA  : 640;
        int hfp = id != 0 ? B_HFP : 16;
        int hs  = id != 0 ? B_HS  : 96;
        int va  = id != 0 ? B_VA  : 480;
        int vfp = id != 0 ? B_VFP : 10;
        int vs  = id != 0 ? B_VS  : 2;
        logic pol = id != 0;
        int p = m % htot(id);
        int l = (m / htot(id)) % vtot(id);
        logic h_on = (p >= ha + hfp) && (p < ha + hfp + hs);
        logic v_on = (l >= va + vfp) && (l < va + vfp + vs);
        return {h_on ? pol : ~pol, v_on ? pol : ~pol, (p < ha) && (l < va)};
    endfunction

    task automatic step(input int id, input bit rst_v, input bit en_v, output exp_t e);
        int       dly = id != 0 ? 0 : 2;
        int       ft  = htot(id) * vtot(id);
        logic [2:0] s;
        e.ls = 1'b0;
        e.fs = 1'b0;
        if (!rst_v) begin
            n[id]       = 0;
            fc_base[id] = 16'd0;
        end else if (en_v) begin
            n[id]++;
            e.ls = (n[id] % htot(id)) == 0;
            e.fs = (n[id] % ft) == 0;
        end
        s       = (n[id] >= dly + 1) ? raw(id, n[id] - dly) : idle(id);
        e.hsync = s[2];
        e.vsync = s[1];
        e.de    = s[0];
        e.pixel = `CORDW'(n[id] % htot(id));
        e.line  = `CORDW'((n[id] / htot(id)) % vtot(id));
        e.fc    = fc_base[id] + 16'(n[id] / ft);
    endtask

    task automatic drive(input int id, input bit rst_v, input bit en_v);
        exp_t e;
        @(negedge clk);
        if (id == 0) begin
            rst_a       = rst_v;
            if_a.pix_en = en_v;
        end else begin
            rst_b       = rst_v;
            if_b.pix_en = en_v;
        end
        step(id, rst_v, en_v, e);
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    task automatic check(input int id, input exp_t e);
        exp_t a;
        if (id == 0) begin
            a = {if_a.pixel, if_a.line, if_a.hsync, if_a.vsync, if_a.de,
                 if_a.line_start, if_a.frame_start, if_a.frame_cnt};
        end else begin
            a = {if_b.pixel, if_b.line, if_b.hsync, if_b.vsync, if_b.de,
                 if_b.line_start, if_b.frame_start, if_b.frame_cnt};
        end
        vectors++;
        if (a !== e) begin
            misc++;
            $display("FAIL dut_%s t=%0t: got px=%0d ln=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%h; want px=%0d ln=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%h",
                     id != 0 ? "b" : "a", $time,
                     a.pixel, a.line, a.hsync, a.vsync, a.de, a.ls, a.fs, a.fc,
                     e.pixel, e.line, e.hsync, e.vsync, e.de, e.ls, e.fs, e.fc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) check(0, q_a.pop_front());
        if (q_b.size() > 0) check(1, q_b.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete, got vectors=%0d, want completion", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        bit alt;
        if_a.pix_en = 1'b0;
        if_b.pix_en = 1'b0;
        n[0] = 0;
        n[1] = 0;
        fc_base[0] = 16'd0;
        fc_base[1] = 16'd0;
        fork
            begin : proc_a
                alt = 1'b0;
                repeat (3) drive(0, 1'b0, 1'($urandom_range(0, 1)));
                // pix_en every 2nd clk through two full lines and up to pixel 300
                while (n[0] < 2 * 800 + 300) begin
                    alt = ~alt;
                    drive(0, 1'b1, alt);
                end
                repeat (50) drive(0, 1'b1, 1'b0);
                while (n[0] < 3 * 800 + 400) drive(0, 1'b1, 1'($urandom_range(0, 1)));
                repeat (3) drive(0, 1'b0, 1'($urandom_range(0, 1)));
                while (n[0] < 1700) drive(0, 1'b1, $urandom_range(0, 3) != 0);
            end
            begin : proc_b
                int ft;
                ft = htot(1) * vtot(1);
                repeat (2) drive(1, 1'b0, 1'b0);
                while (n[1] < 3 * ft + 20) drive(1, 1'b1, 1'($urandom_range(0, 1)));
                repeat (2) drive(1, 1'b0, 1'b1);
                while (n[1] < 2 * ft) drive(1, 1'b1, 1'b1);
                // Preload the frame counter near the top so the wrap is reached quickly
                @(negedge clk);
                if_b.pix_en = 1'b0;
                force dut_b.frame_cnt_q = 16'hFFFD;
                #1;
                release dut_b.frame_cnt_q;
                fc_base[1] = 16'hFFFD - 16'(n[1] / ft);
                while (n[1] < 6 * ft) drive(1, 1'b1, $urandom_range(0, 3) != 0);
            end
        join
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
